reg_bank_sb: RTL and testbench

Parametrised, multi-ported integer register bank with a per-register scoreboard and optional write-to-read bypass. It is the next generation of the core's 32x32 two-read/one-write register file and replaces it in the decode/writeback path. It adds configurable width, depth and read-port count, a second write port, synchronous clear, and pending-write tracking for hazard detection at issue.

---
 rtl/reg_bank_pkg.sv | 16 +
 rtl/reg_bank_rd_port.sv | 47 ++++
 rtl/reg_bank_sb.sv | 122 ++++++++++++
 tb/tb_reg_bank_sb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the register bank and its read ports.
package reg_bank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // Register index that is hardwired to zero when ZERO_REG is enabled.
  localparam int ZERO_ADDR = 0;

  // Low bit of field idx inside a flattened vector of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// One combinational read port: bypass mux, zero-register force, busy mask.
module reg_bank_rd_port
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  // Select stored or forwarded value; zero register and reset override last.
  always_comb begin
    data = stored_data;
    busy = stored_busy;
    if (BYPASS) begin
      if (wr1_en && (wr1_addr == addr)) begin
        data = wr1_data;
        busy = 1'b0;
      end else if (wr0_en && (wr0_addr == addr)) begin
        data = wr0_data;
        busy = 1'b0;
      end
    end
    if (ZERO_REG && (addr == ADDR_W'(ZERO_ADDR))) begin
      data = '0;
      busy = 1'b0;
    end
    if (rst) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_bank_sb.sv
// Multi-ported register bank with per-register busy scoreboard.
// Storage, busy vector, write arbitration and busy counter live here;
// read ports are replicated sub-modules.
//
// Reservation handshake: rsv_en is a valid, rsv_ready is a ready; a
// reservation is taken on a rising edge only when both are high, and
// rsv_en without rsv_ready is simply dropped (the issuer must stall).
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [CNT_W-1:0]  cnt_next;

  logic w0_eff, w1_eff, rsv_eff;
  logic inc, dec0, dec1;

  // Reservation is possible when the target is idle or is the zero register.
  always_comb begin
    rsv_ready = !rst &&
                (!busy[rsv_addr] || (ZERO_REG && (rsv_addr == ADDR_W'(ZERO_ADDR))));
  end

  // Effective events: writes and reservations to a hardwired x0 do nothing.
  always_comb begin
    w0_eff  = wr0_en && !(ZERO_REG && (wr0_addr == ADDR_W'(ZERO_ADDR)));
    w1_eff  = wr1_en && !(ZERO_REG && (wr1_addr == ADDR_W'(ZERO_ADDR)));
    rsv_eff = rsv_en && rsv_ready && !(ZERO_REG && (rsv_addr == ADDR_W'(ZERO_ADDR)));
  end

  // Next busy vector: writes clear, a same-cycle reservation wins.
  always_comb begin
    busy_next = busy;
    if (w0_eff) busy_next[wr0_addr] = 1'b0;
    if (w1_eff) busy_next[wr1_addr] = 1'b0;
    if (rsv_eff) busy_next[rsv_addr] = 1'b1;
  end

  // Incremental busy count; a double write to one register clears it once.
  // An accepted reservation always targets an idle register, so a write to
  // the same address in that cycle finds the bit clear and does not count.
  always_comb begin
    inc      = rsv_eff && !busy[rsv_addr];
    dec0     = w0_eff && busy[wr0_addr];
    dec1     = w1_eff && busy[wr1_addr] && !(w0_eff && (wr0_addr == wr1_addr));
    cnt_next = busy_cnt + CNT_W'(inc) - CNT_W'(dec0) - CNT_W'(dec1);
  end

  // Data array: port 1 is written last so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (w0_eff) regs[wr0_addr] <= wr0_data;
      if (w1_eff) regs[wr1_addr] <= wr1_data;
    end
  end

  // Busy vector and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[slice_lo(g, ADDR_W) +: ADDR_W];

    reg_bank_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .rst        (rst),
      .addr       (a),
      .stored_data(regs[a]),
      .stored_busy(busy[a]),
      .wr0_en     (wr0_en),
      .wr0_addr   (wr0_addr),
      .wr0_data   (wr0_data),
      .wr1_en     (wr1_en),
      .wr1_addr   (wr1_addr),
      .wr1_data   (wr1_data),
      .data       (rd_data[slice_lo(g, DATA_W) +: DATA_W]),
      .busy       (rd_busy[g])
    );
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench: one bypass instance and one read-old instance share stimulus.
module tb_reg_bank_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr0_en, wr1_en, rsv_en;
  logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [9:0]  rd_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        rsv_ready_b, rsv_ready_n;
  logic [5:0]  busy_cnt_b, busy_cnt_n;

  int total = 0;
  int bad   = 0;

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  reg_bank_sb #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_b),
    .busy_cnt(busy_cnt_b)
  );

  reg_bank_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_n),
    .busy_cnt(busy_cnt_n)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    rsv_en = 0; rsv_addr = 0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    idle(); set_rd(0, 0); rst = 1;
    tick();
    #1;
    total++; if (busy_cnt_b !== 6'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", busy_cnt_b); end
    total++; if (rsv_ready_b !== 1'b0) begin bad++; $display("FAIL rst_ready_hi got=%b exp=0", rsv_ready_b); end
    total++; if (rd_data_b !== 64'd0) begin bad++; $display("FAIL rst_data_hi got=%h exp=0", rd_data_b); end
    rst = 0;
    #1;
    total++; if (rsv_ready_b !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", rsv_ready_b); end
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      total++;
      if (rd_data_b !== 64'd0 || rd_busy_b !== 2'b00 || rd_data_n !== 64'd0 || rd_busy_n !== 2'b00) begin
        bad++;
        $display("FAIL rst_read a=%0d got=%h/%b exp=0/00", a, rd_data_b, rd_busy_b);
      end
    end
  endtask

  task automatic test_bypass();
    idle(); set_rd(5, 0);
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    #1;
    total++; if (rd_data_b[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL byp_same got=%h exp=deadbeef", rd_data_b[31:0]); end
    total++; if (rd_data_n[31:0] !== 32'h0) begin bad++; $display("FAIL nobyp_same got=%h exp=0", rd_data_n[31:0]); end
    tick(); idle();
    #1;
    total++; if (rd_data_b[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL byp_next got=%h exp=deadbeef", rd_data_b[31:0]); end
    total++; if (rd_data_n[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL nobyp_next got=%h exp=deadbeef", rd_data_n[31:0]); end
  endtask

  task automatic test_dual_write();
    idle(); set_rd(0, 7);
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22;
    #1;
    total++; if (rd_data_b[63:32] !== 32'h22) begin bad++; $display("FAIL dual_byp got=%h exp=22", rd_data_b[63:32]); end
    total++; if (rd_data_n[63:32] !== 32'h0) begin bad++; $display("FAIL dual_old got=%h exp=0", rd_data_n[63:32]); end
    tick(); idle();
    #1;
    total++; if (rd_data_b[63:32] !== 32'h22) begin bad++; $display("FAIL dual_next_b got=%h exp=22", rd_data_b[63:32]); end
    total++; if (rd_data_n[63:32] !== 32'h22) begin bad++; $display("FAIL dual_next_n got=%h exp=22", rd_data_n[63:32]); end
  endtask

  task automatic test_reserve();
    idle(); set_rd(3, 0);
    rsv_en = 1; rsv_addr = 3;
    #1;
    total++; if (rsv_ready_b !== 1'b1) begin bad++; $display("FAIL rsv_ready_idle got=%b exp=1", rsv_ready_b); end
    tick(); rsv_en = 0;
    #1;
    total++; if (rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1) begin bad++; $display("FAIL rsv_busy got=%b/%b exp=1", rd_busy_b[0], rd_busy_n[0]); end
    total++; if (busy_cnt_b !== 6'd1) begin bad++; $display("FAIL rsv_cnt got=%0d exp=1", busy_cnt_b); end
    total++; if (rsv_ready_b !== 1'b0) begin bad++; $display("FAIL rsv_ready_busy got=%b exp=0", rsv_ready_b); end
    rsv_en = 1;
    tick(); rsv_en = 0;
    #1;
    total++; if (busy_cnt_b !== 6'd1 || busy_cnt_n !== 6'd1) begin bad++; $display("FAIL rsv_drop_cnt got=%0d exp=1", busy_cnt_b); end
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h33;
    #1;
    total++; if (rd_busy_b[0] !== 1'b0) begin bad++; $display("FAIL wr_busy_byp got=%b exp=0", rd_busy_b[0]); end
    total++; if (rd_busy_n[0] !== 1'b1) begin bad++; $display("FAIL wr_busy_old got=%b exp=1", rd_busy_n[0]); end
    tick(); idle();
    #1;
    total++; if (rd_busy_n[0] !== 1'b0 || rd_data_n[31:0] !== 32'h33) begin bad++; $display("FAIL wr_clear got=%b/%h exp=0/33", rd_busy_n[0], rd_data_n[31:0]); end
    total++; if (busy_cnt_b !== 6'd0) begin bad++; $display("FAIL wr_clear_cnt got=%0d exp=0", busy_cnt_b); end
  endtask

  task automatic test_rsv_write_same();
    idle(); set_rd(9, 0);
    rsv_en = 1; rsv_addr = 9;
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99;
    tick(); idle();
    #1;
    total++; if (rd_busy_b[0] !== 1'b1 || rd_data_b[31:0] !== 32'h99) begin bad++; $display("FAIL rsvwr got=%b/%h exp=1/99", rd_busy_b[0], rd_data_b[31:0]); end
    total++; if (busy_cnt_b !== 6'd1) begin bad++; $display("FAIL rsvwr_cnt got=%0d exp=1", busy_cnt_b); end
    set_rd(9, 0);
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    rsv_en = 1; rsv_addr = 0;
    #1;
    total++; if (rsv_ready_b !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", rsv_ready_b); end
    total++; if (rd_data_b[63:32] !== 32'h0) begin bad++; $display("FAIL x0_byp got=%h exp=0", rd_data_b[63:32]); end
    tick(); idle();
    #1;
    total++; if (rd_data_n[63:32] !== 32'h0 || rd_busy_n[1] !== 1'b0) begin bad++; $display("FAIL x0_read got=%h/%b exp=0/0", rd_data_n[63:32], rd_busy_n[1]); end
    total++; if (busy_cnt_b !== 6'd1) begin bad++; $display("FAIL x0_cnt got=%0d exp=1", busy_cnt_b); end
  endtask

  task automatic test_reset_mid();
    idle(); set_rd(1, 5);
    rsv_en = 1; rsv_addr = 1; tick();
    rsv_addr = 2; tick();
    rsv_addr = 4; tick();
    idle();
    #1;
    total++; if (busy_cnt_b !== 6'd4) begin bad++; $display("FAIL mid_cnt got=%0d exp=4", busy_cnt_b); end
    rst = 1;
    wr0_en = 1; wr0_addr = 1; wr0_data = 32'h1234;
    rsv_en = 1; rsv_addr = 6;
    #1;
    total++; if (rd_data_b !== 64'd0 || rd_busy_b !== 2'b00) begin bad++; $display("FAIL mid_rst_read got=%h/%b exp=0/00", rd_data_b, rd_busy_b); end
    total++; if (rsv_ready_b !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", rsv_ready_b); end
    tick(); rst = 0; idle();
    #1;
    total++; if (busy_cnt_b !== 6'd0 || busy_cnt_n !== 6'd0) begin bad++; $display("FAIL mid_after_cnt got=%0d exp=0", busy_cnt_b); end
    total++; if (rd_data_n !== 64'd0) begin bad++; $display("FAIL mid_after_data got=%h exp=0", rd_data_n); end
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(a));
      #1;
      total++; if (rd_busy_n !== 2'b00) begin bad++; $display("FAIL mid_busy a=%0d got=%b exp=00", a, rd_busy_n); end
    end
  endtask

  task automatic test_back_to_back();
    idle(); set_rd(20, 21);
    rsv_en = 1; rsv_addr = 20; tick();
    rsv_addr = 21; tick();
    idle();
    #1;
    total++; if (busy_cnt_b !== 6'd2) begin bad++; $display("FAIL b2b_cnt2 got=%0d exp=2", busy_cnt_b); end
    wr0_en = 1; wr0_addr = 20; wr0_data = 32'hAAAA0001;
    wr1_en = 1; wr1_addr = 21; wr1_data = 32'hBBBB0002;
    #1;
    total++; if (rd_data_b !== {32'hBBBB0002, 32'hAAAA0001} || rd_busy_b !== 2'b00) begin bad++; $display("FAIL b2b_byp got=%h/%b exp=bbbb0002aaaa0001/00", rd_data_b, rd_busy_b); end
    tick(); idle();
    #1;
    total++; if (busy_cnt_b !== 6'd0) begin bad++; $display("FAIL b2b_cnt0 got=%0d exp=0", busy_cnt_b); end
    total++; if (rd_data_n !== {32'hBBBB0002, 32'hAAAA0001}) begin bad++; $display("FAIL b2b_store got=%h exp=bbbb0002aaaa0001", rd_data_n); end
    set_rd(22, 22);
    rsv_en = 1; rsv_addr = 22; tick(); idle();
    wr0_en = 1; wr0_addr = 22; wr0_data = 32'h5;
    wr1_en = 1; wr1_addr = 22; wr1_data = 32'h6;
    tick(); idle();
    #1;
    total++; if (busy_cnt_b !== 6'd0) begin bad++; $display("FAIL dup_clear_cnt got=%0d exp=0", busy_cnt_b); end
    total++; if (rd_data_n[31:0] !== 32'h6) begin bad++; $display("FAIL dup_data got=%h exp=6", rd_data_n[31:0]); end
  endtask

  // Test sequence and final report
  initial begin
    idle(); rst = 1; rd_addr = '0;
    test_reset();
    test_bypass();
    test_dual_write();
    test_reserve();
    test_rsv_write_same();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
